// File: rtl/ir_wand_tx_pkg.sv
// Shared types and constants for the wand IR transmitter.
// Build option: define IR_CHECKSUM_EN to append an 8-bit inverted-XOR check byte (24-bit frames).
package ir_tx_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEAD_MARK  = 3'd1,
    LEAD_SPACE = 3'd2,
    BIT_MARK   = 3'd3,
    BIT_SPACE  = 3'd4,
    STOP_MARK  = 3'd5,
    GAP        = 3'd6
  } tx_state_e;

  localparam int unsigned LEAD_MARK_U  = 16;
  localparam int unsigned LEAD_SPACE_U = 8;
  localparam int unsigned ONE_SPACE_U  = 3;
  localparam int unsigned ZERO_SPACE_U = 1;

`ifdef IR_CHECKSUM_EN
  localparam int unsigned NBITS = 24;
`else
  localparam int unsigned NBITS = 16;
`endif

  function automatic logic [NBITS-1:0] frame_payload(input logic [15:0] code);
`ifdef IR_CHECKSUM_EN
    return {code, ~(code[15:8] ^ code[7:0])};
`else
    return code;
`endif
  endfunction

endpackage

// File: rtl/ir_wand_tx_if.sv
// Code-offer handshake between the wand controller (master) and the IR transmitter (slave).
interface ir_wand_tx_if;
  logic        tx_valid;
  logic [15:0] tx_code;
  logic        tx_ready;

  modport master (output tx_valid, output tx_code, input tx_ready);
  modport slave  (input tx_valid, input tx_code, output tx_ready);
endinterface

// File: rtl/ir_wand_tx_carrier_gen.sv
// Square-wave carrier, toggling every HALF_CYC cycles while enabled; clear restarts it high.
module ir_carrier_gen #(
  parameter int unsigned HALF_CYC = 657
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic carrier_o
);
  localparam int unsigned PW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

  logic [PW-1:0] phase_q, phase_d;
  logic          carrier_q, carrier_d;

  always_comb begin
    phase_d   = phase_q;
    carrier_d = carrier_q;
    if (clear_i) begin
      phase_d   = '0;
      carrier_d = 1'b1;
    end else if (enable_i) begin
      if (phase_q == PW'(HALF_CYC - 1)) begin
        phase_d   = '0;
        carrier_d = ~carrier_q;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      phase_q   <= '0;
      carrier_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      carrier_q <= carrier_d;
    end
  end

  // Next-cycle value: lets the caller register the LED in phase with the carrier.
  assign carrier_o = carrier_d;

endmodule

// File: rtl/ir_wand_tx.sv
// Wand IR transmitter: pulse-distance framing, MSB-first, marks gated by the carrier.
// Build option: IR_CHECKSUM_EN selects 24-bit frames (code + check byte).
module ir_wand_tx
  import ir_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned CARRIER_HZ = 38_000,
  parameter int unsigned UNIT_US    = 562,
  parameter int unsigned GAP_UNITS  = 40
) (
  input  logic         clock,
  input  logic         resetn,
  ir_wand_tx_if.slave  tx,
  output logic         ir_led_out,
  output logic         busy,
  output logic         frame_done
);
  localparam int unsigned HALF_CYC = CLK_HZ / (2 * CARRIER_HZ);
  localparam int unsigned UNIT_CYC = (CLK_HZ / 1_000_000) * UNIT_US;
  localparam int unsigned GAP_CYC  = UNIT_CYC * GAP_UNITS;
  localparam int unsigned CNT_W    = $clog2(GAP_CYC + 1);
  localparam int unsigned BIT_W    = $clog2(NBITS);

  localparam logic [CNT_W-1:0] LM_END   = CNT_W'(UNIT_CYC * LEAD_MARK_U - 1);
  localparam logic [CNT_W-1:0] LS_END   = CNT_W'(UNIT_CYC * LEAD_SPACE_U - 1);
  localparam logic [CNT_W-1:0] UNIT_END = CNT_W'(UNIT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_END  = CNT_W'(UNIT_CYC * ONE_SPACE_U - 1);
  localparam logic [CNT_W-1:0] ZERO_END = CNT_W'(UNIT_CYC * ZERO_SPACE_U - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_CYC - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic             led_q, ready_q, done_q;
  logic             accept, carrier_nxt, mark_d;

  assign accept = tx.tx_valid & ready_q;

  ir_carrier_gen #(.HALF_CYC(HALF_CYC)) u_carrier (
    .clock     (clock),
    .resetn    (resetn),
    .clear_i   (accept),
    .enable_i  (state_q != IDLE),
    .carrier_o (carrier_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = LEAD_MARK;
          shreg_d = frame_payload(tx.tx_code);
          bit_d   = '0;
        end
      end
      LEAD_MARK:  if (cnt_q == LM_END)   begin state_d = LEAD_SPACE; cnt_d = '0; end
      LEAD_SPACE: if (cnt_q == LS_END)   begin state_d = BIT_MARK;   cnt_d = '0; end
      BIT_MARK:   if (cnt_q == UNIT_END) begin state_d = BIT_SPACE;  cnt_d = '0; end
      BIT_SPACE: begin
        if (cnt_q == (shreg_q[NBITS-1] ? ONE_END : ZERO_END)) begin
          cnt_d   = '0;
          shreg_d = shreg_q << 1;
          if (bit_q == BIT_W'(NBITS - 1)) begin
            state_d = STOP_MARK;
          end else begin
            state_d = BIT_MARK;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      STOP_MARK:  if (cnt_q == UNIT_END) begin state_d = GAP;  cnt_d = '0; end
      GAP:        if (cnt_q == GAP_END)  begin state_d = IDLE; cnt_d = '0; end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mark_d = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

  // Outputs are decoded from next-state so each flop holds the value for the cycle it labels.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      led_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      led_q   <= mark_d & carrier_nxt;
      ready_q <= (state_d == IDLE);
      done_q  <= (state_d == GAP) && (cnt_d == GAP_END);
    end
  end

  assign tx.tx_ready = ready_q;
  assign busy        = ~ready_q;
  assign ir_led_out  = led_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_ir_wand_tx.sv
// Randomized frame bench for ir_wand_tx: decodes the LED envelope and compares against a frame model.
module tb_ir_wand_tx;
  localparam int HALF    = 10;
  localparam int UNIT    = 20;
  localparam int GAP_CYC = 40 * UNIT;
`ifdef IR_CHECKSUM_EN
  localparam int NB = 24;
`else
  localparam int NB = 16;
`endif

  logic clock = 1'b0;
  logic resetn;
  logic ir_led_out, busy, frame_done;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   first_hi, last_hi;
  logic [31:0] last_word;

  ir_wand_tx_if tx_if ();

  ir_wand_tx #(
    .CLK_HZ     (1_000_000),
    .CARRIER_HZ (50_000),
    .UNIT_US    (20),
    .GAP_UNITS  (40)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .tx         (tx_if),
    .ir_led_out (ir_led_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] payload(input logic [15:0] code);
`ifdef IR_CHECKSUM_EN
    return {code, ~(code[15:8] ^ code[7:0])};
`else
    return code;
`endif
  endfunction

  // Starts at a negedge in IDLE; returns at the negedge of the IDLE cycle after frame_done.
  task automatic run_frame(input logic [15:0] code, input bit hold, input bit inject);
    bit          samples[$];
    int          marks[$], spaces[$];
    int          k, i, j, run, cur, ones, exp_len;
    int          bad_half, bad_mark, bad_space;
    logic [NB-1:0] expw;
    logic [31:0] word;

    expw = payload(code);
    ones = 0;
    for (int b = 0; b < NB; b++) ones += int'(expw[b]);
    exp_len = UNIT * (LEAD_MARK_UNITS() + (NB - ones) * 2 + ones * 4 + 1 + 40);

    tx_if.tx_valid = 1'b1;
    tx_if.tx_code  = code;
    k = 0;
    first_hi = -1;
    do begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        check_eq("ready_fall", tx_if.tx_ready, 0);
        check_eq("busy_rise", busy, 1);
        check_eq("led_first", ir_led_out, 1);
        if (!hold) tx_if.tx_valid = 1'b0;
      end
      if (hold) tx_if.tx_code = 16'($urandom);
      if (inject && k == 100) begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_code  = 16'hFFFF;
      end else if (inject && k == 101) begin
        tx_if.tx_valid = 1'b0;
      end
      samples.push_back(ir_led_out);
      if (ir_led_out) begin
        if (first_hi < 0) first_hi = cyc;
        last_hi = cyc;
      end
    end while (!frame_done && k < 4000);
    check_eq("frame_len", k, exp_len);

    // Envelope: a low run of exactly HALF between highs is the carrier; longer runs are spaces.
    i = 0; cur = 0; bad_half = 0;
    while (i < samples.size()) begin
      j = i;
      while (j < samples.size() && samples[j] == samples[i]) j++;
      run = j - i;
      if (samples[i]) begin
        cur += run;
        if (run != HALF) bad_half++;
      end else if (j < samples.size() && run == HALF) begin
        cur += run;
      end else begin
        if (run < HALF) bad_half++;
        marks.push_back(cur + HALF);
        spaces.push_back(run - HALF);
        cur = 0;
      end
      i = j;
    end
    check_eq("carrier_half", bad_half, 0);
    check_eq("n_marks", marks.size(), NB + 2);
    if (marks.size() == NB + 2 && spaces.size() == NB + 2) begin
      check_eq("lead_mark", marks[0], 16 * UNIT);
      check_eq("lead_space", spaces[0], 8 * UNIT);
      check_eq("gap_space", spaces[NB + 1], GAP_CYC);
      word = '0; bad_mark = 0; bad_space = 0;
      for (int b = 0; b < NB; b++) begin
        if (marks[b + 1] != UNIT) bad_mark++;
        if (spaces[b + 1] != UNIT && spaces[b + 1] != 3 * UNIT) bad_space++;
        word = {word[30:0], spaces[b + 1] == 3 * UNIT};
      end
      if (marks[NB + 1] != UNIT) bad_mark++;
      check_eq("bit_marks", bad_mark, 0);
      check_eq("bit_spaces", bad_space, 0);
      check_eq("word", word, 32'(expw));
      last_word = word;
    end

    @(negedge clock);
    check_eq("done_pulse", frame_done, 0);
    check_eq("ready_after", tx_if.tx_ready, 1);
  endtask

  function automatic int LEAD_MARK_UNITS();
    return 16 + 8;
  endfunction

  initial begin
    int lo_between, fd_seen, led_seen;
    resetn = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_code  = '0;
    last_word = '0;
    repeat (5) @(negedge clock);
    check_eq("rst_ready", tx_if.tx_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_led", ir_led_out, 0);
    check_eq("rst_done", frame_done, 0);
    resetn = 1'b1;
    @(negedge clock);

    // Directed frame with a stray offer mid-frame that must be ignored.
    run_frame(16'hA5C3, 1'b0, 1'b1);

    for (int n = 0; n < 4; n++) run_frame(16'($urandom), 1'b0, 1'b0);

    // Back-to-back: low stretch = stop-mark carrier low half + GAP + the IDLE handshake cycle.
    run_frame(16'($urandom), 1'b1, 1'b0);
    lo_between = last_hi;
    run_frame(16'($urandom), 1'b1, 1'b0);
    tx_if.tx_valid = 1'b0;
    check_eq("b2b_gap", first_hi - lo_between - 1, HALF + GAP_CYC + 1);
    repeat (3) @(negedge clock);

    // Reset asserted during the first BIT_SPACE.
    tx_if.tx_valid = 1'b1;
    tx_if.tx_code  = 16'($urandom);
    for (int k = 1; k <= 505; k++) begin
      @(negedge clock);
      tx_if.tx_valid = 1'b0;
    end
    resetn = 1'b0;
    @(negedge clock);
    check_eq("mid_rst_led", ir_led_out, 0);
    check_eq("mid_rst_ready", tx_if.tx_ready, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", frame_done, 0);
    resetn = 1'b1;
    fd_seen = 0; led_seen = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      fd_seen  += int'(frame_done);
      led_seen += int'(ir_led_out);
    end
    check_eq("post_rst_done", fd_seen, 0);
    check_eq("post_rst_led", led_seen, 0);

`ifdef IR_CHECKSUM_EN
    run_frame(16'h1234, 1'b0, 1'b0);
    check_eq("chk_byte", last_word[7:0], 8'hD9);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
